// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: round-robin arbitration of the ALU and
// load writeback sources onto the single write port (WE3/A3/WD3), plus a
// busy scoreboard of destination registers that drives the issue-stage stall.
//
// Handshake: a transfer happens at a rising edge where a source's valid and
// its ready are both 1. A source holds valid/rd/data stable until ready.
// ready is combinational from valid and the round-robin pointer, is never
// asserted without the matching valid, and is forced low while RST is high.
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  input  logic [AW-1:0]      chk_rs1,
  input  logic [AW-1:0]      chk_rs2,
  output logic               stall,
  input  logic               alu_valid,
  input  logic [AW-1:0]      alu_rd,
  input  logic [XLEN-1:0]    alu_data,
  output logic               alu_ready,
  input  logic               mem_valid,
  input  logic [AW-1:0]      mem_rd,
  input  logic [XLEN-1:0]    mem_data,
  output logic               mem_ready,
  output logic               WE3,
  output logic [AW-1:0]      A3,
  output logic [XLEN-1:0]    WD3,
  output logic [(1<<AW)-1:0] busy_vec
);

  localparam int NREG = 1 << AW;

  // Round-robin pointer: names the source that wins when both request.
  typedef enum logic {
    RR_ALU = 1'b0,
    RR_MEM = 1'b1
  } rr_state_t;

  rr_state_t         rr_q, rr_d;
  logic              we3_q, we3_d;
  logic [AW-1:0]     a3_q, a3_d;
  logic [XLEN-1:0]   wd3_q, wd3_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              alu_grant;
  logic              mem_grant;
  logic              iss_accept;

  // Arbitration: single requester wins outright, contention goes to the pointer.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    rr_d      = rr_q;
    if (!RST) begin
      if (alu_valid && (!mem_valid || rr_q == RR_ALU)) begin
        alu_grant = 1'b1;
      end else if (mem_valid) begin
        mem_grant = 1'b1;
      end
    end
    // After any grant the pointer moves to the other source; otherwise it holds.
    if (alu_grant) begin
      rr_d = RR_MEM;
    end else if (mem_grant) begin
      rr_d = RR_ALU;
    end
  end

  // Write-port next state: an accepted rd=0 transfer writes nothing and the
  // address/data registers keep their previous contents.
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (alu_grant && alu_rd != '0) begin
      we3_d = 1'b1;
      a3_d  = alu_rd;
      wd3_d = alu_data;
    end else if (mem_grant && mem_rd != '0) begin
      we3_d = 1'b1;
      a3_d  = mem_rd;
      wd3_d = mem_data;
    end
  end

  // Hazard stall: any busy source, or a busy destination when issuing (WAW).
  // busy_q[0] is held at 0, so register 0 never contributes.
  always_comb begin
    stall      = busy_q[chk_rs1] | busy_q[chk_rs2] | (iss_valid & busy_q[iss_rd]);
    iss_accept = iss_valid & ~stall & (iss_rd != '0);
  end

  // Scoreboard: the commit clears first so a same-edge issue to that rd wins.
  always_comb begin
    busy_d = busy_q;
    if (we3_q) begin
      busy_d[a3_q] = 1'b0;
    end
    if (iss_accept) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset; reset also cancels a pending write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q   <= RR_ALU;
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      busy_q <= '0;
    end else begin
      rr_q   <= rr_d;
      we3_q  <= we3_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      busy_q <= busy_d;
    end
  end

  // Output mapping.
  always_comb begin
    alu_ready = alu_grant;
    mem_ready = mem_grant;
    WE3       = we3_q;
    A3        = a3_q;
    WD3       = wd3_q;
    busy_vec  = busy_q;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed testbench for regfile_wb_scheduler: reset, issue/writeback/stall
// timing, round-robin contention, x0 writes, same-edge set/clear and a
// reset in the middle of traffic.
module tb_regfile_wb_scheduler;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            CLK;
  logic            RST;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   chk_rs1;
  logic [AW-1:0]   chk_rs2;
  logic            stall;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            WE3;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;
  logic [31:0]     busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected register-file writes, {address, data}, in commit order.
  logic [AW+XLEN-1:0] exp_q[$];

  regfile_wb_scheduler #(.XLEN(XLEN), .AW(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .stall     (stall),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .busy_vec  (busy_vec)
  );

  // Clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_mem(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    mem_valid = v;
    mem_rd    = rd;
    mem_data  = d;
  endtask

  task automatic drive_iss(input logic v, input logic [AW-1:0] rd);
    iss_valid = v;
    iss_rd    = rd;
  endtask

  // Scoreboard: every write-port pulse must match the next expected write.
  always @(negedge CLK) begin
    if (WE3 === 1'b1) begin
      check_eq("wr_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check_eq("wr_addr_data", {A3, WD3}, exp_q.pop_front());
      end
    end
  end

  initial begin
    RST = 1'b1;
    drive_iss(1'b0, '0);
    chk_rs1 = '0;
    chk_rs2 = '0;
    // Valids high during reset to show readies are forced low.
    drive_alu(1'b1, 5'd4, 32'h0000_0004);
    drive_mem(1'b1, 5'd6, 32'h0000_0006);

    // ---- Reset ----
    step();
    step();
    check_eq("rst_we3", WE3, 0);
    check_eq("rst_a3", A3, 0);
    check_eq("rst_wd3", WD3, 0);
    check_eq("rst_busy", busy_vec, 0);
    check_eq("rst_alu_ready", alu_ready, 0);
    check_eq("rst_mem_ready", mem_ready, 0);
    drive_alu(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    RST = 1'b0;
    step();

    // ---- Issue rd=5, writeback three cycles later ----
    drive_iss(1'b1, 5'd5);
    chk_rs1 = 5'd5;
    #1;
    check_eq("iss_stall_free", stall, 0);
    step();
    drive_iss(1'b0, '0);
    #1;
    check_eq("iss_busy5", busy_vec, 32'h0000_0020);
    check_eq("iss_stall_c1", stall, 1);
    // Stalled issue of rd=6 must be ignored.
    drive_iss(1'b1, 5'd6);
    step();
    drive_iss(1'b0, '0);
    #1;
    check_eq("stalled_iss_ignored", busy_vec, 32'h0000_0020);
    check_eq("iss_stall_c2", stall, 1);
    step();
    drive_alu(1'b1, 5'd5, 32'hAAAA_BBBB);
    exp_q.push_back({5'd5, 32'hAAAA_BBBB});
    #1;
    check_eq("wb5_alu_ready", alu_ready, 1);
    check_eq("wb5_stall_req", stall, 1);
    step();
    drive_alu(1'b0, '0, '0);
    #1;
    check_eq("wb5_we3", WE3, 1);
    check_eq("wb5_a3", A3, 5);
    check_eq("wb5_wd3", WD3, 32'hAAAA_BBBB);
    check_eq("wb5_stall_commit", stall, 1);
    check_eq("wb5_busy_commit", busy_vec, 32'h0000_0020);
    step();
    check_eq("wb5_busy_cleared", busy_vec, 0);
    check_eq("wb5_stall_dropped", stall, 0);
    check_eq("wb5_we3_off", WE3, 0);
    chk_rs1 = '0;

    // ---- x0 write from MEM (pointer currently MEM) ----
    drive_mem(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check_eq("x0_mem_ready", mem_ready, 1);
    check_eq("x0_alu_ready", alu_ready, 0);
    step();
    drive_mem(1'b0, '0, '0);
    #1;
    check_eq("x0_we3", WE3, 0);
    check_eq("x0_a3_hold", A3, 5);
    check_eq("x0_wd3_hold", WD3, 32'hAAAA_BBBB);
    check_eq("x0_busy", busy_vec, 0);

    // ---- Contention: pointer back at ALU after the x0 grant ----
    drive_alu(1'b1, 5'd1, 32'h1111_1111);
    drive_mem(1'b1, 5'd2, 32'h2222_2222);
    exp_q.push_back({5'd1, 32'h1111_1111});
    exp_q.push_back({5'd2, 32'h2222_2222});
    #1;
    check_eq("ct1_alu_ready", alu_ready, 1);
    check_eq("ct1_mem_ready", mem_ready, 0);
    step();
    drive_alu(1'b0, '0, '0);
    #1;
    check_eq("ct1_we3", WE3, 1);
    check_eq("ct1_a3", A3, 1);
    check_eq("ct2_mem_ready", mem_ready, 1);
    step();
    drive_mem(1'b0, '0, '0);
    #1;
    check_eq("ct2_we3", WE3, 1);
    check_eq("ct2_a3", A3, 2);
    check_eq("ct2_wd3", WD3, 32'h2222_2222);
    step();
    check_eq("ct_idle_we3", WE3, 0);

    // ---- Repeat contention: ALU first again, then MEM wins over a new ALU request ----
    drive_alu(1'b1, 5'd1, 32'h1111_0001);
    drive_mem(1'b1, 5'd2, 32'h2222_0002);
    exp_q.push_back({5'd1, 32'h1111_0001});
    exp_q.push_back({5'd2, 32'h2222_0002});
    exp_q.push_back({5'd3, 32'h3333_3333});
    #1;
    check_eq("rp1_alu_ready", alu_ready, 1);
    check_eq("rp1_mem_ready", mem_ready, 0);
    step();
    drive_alu(1'b1, 5'd3, 32'h3333_3333);
    #1;
    check_eq("rp1_a3", A3, 1);
    check_eq("rp2_mem_ready", mem_ready, 1);
    check_eq("rp2_alu_ready", alu_ready, 0);
    step();
    drive_mem(1'b0, '0, '0);
    #1;
    check_eq("rp2_a3", A3, 2);
    check_eq("rp3_alu_ready", alu_ready, 1);
    step();
    drive_alu(1'b0, '0, '0);
    #1;
    check_eq("rp3_a3", A3, 3);
    check_eq("rp3_wd3", WD3, 32'h3333_3333);
    step();

    // ---- Same-edge set and clear on rd=7 ----
    drive_alu(1'b1, 5'd7, 32'h7777_7777);
    exp_q.push_back({5'd7, 32'h7777_7777});
    step();
    drive_alu(1'b0, '0, '0);
    drive_iss(1'b1, 5'd7);
    #1;
    check_eq("se_we3", WE3, 1);
    check_eq("se_a3", A3, 7);
    check_eq("se_stall", stall, 0);
    step();
    drive_iss(1'b0, '0);
    #1;
    check_eq("se_busy7_set", busy_vec, 32'h0000_0080);

    // ---- Mid-flight reset ----
    drive_iss(1'b1, 5'd3);
    step();
    drive_iss(1'b0, '0);
    drive_alu(1'b1, 5'd9, 32'h9999_9999);
    exp_q.push_back({5'd9, 32'h9999_9999});
    #1;
    check_eq("mf_busy_pre", busy_vec, 32'h0000_0088);
    step();
    // Pointer now MEM; reset arrives with both sources requesting.
    RST = 1'b1;
    drive_alu(1'b1, 5'd11, 32'hBBBB_0011);
    drive_mem(1'b1, 5'd10, 32'hAAAA_0010);
    #1;
    check_eq("mf_we3_9", WE3, 1);
    check_eq("mf_rst_alu_ready", alu_ready, 0);
    check_eq("mf_rst_mem_ready", mem_ready, 0);
    step();
    check_eq("mf_we3_cancel", WE3, 0);
    check_eq("mf_busy_clear", busy_vec, 0);
    RST = 1'b0;
    exp_q.push_back({5'd11, 32'hBBBB_0011});
    exp_q.push_back({5'd10, 32'hAAAA_0010});
    #1;
    check_eq("mf_post_alu_ready", alu_ready, 1);
    check_eq("mf_post_mem_ready", mem_ready, 0);
    step();
    drive_alu(1'b0, '0, '0);
    #1;
    check_eq("mf_a3_11", A3, 11);
    check_eq("mf_mem_ready2", mem_ready, 1);
    step();
    drive_mem(1'b0, '0, '0);
    #1;
    check_eq("mf_a3_10", A3, 10);
    step();
    step();
    check_eq("final_we3", WE3, 0);
    check_eq("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
